// File: rtl/data_mem_unit.sv
// Data memory unit: byte-addressable 32-bit word store with sized and
// sign-aware loads. Loads take two cycles (request + READ) and stall the
// pipeline for the request cycle. Stores complete in a single cycle.
module data_mem_unit #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        fault
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [1:0]              off_q, off_d;
  logic [2:0]              f3_q, f3_d;
  logic [31:0]             mem [DEPTH];
  logic [31:0]             rword_q;
  logic [ADDR_WIDTH-1:0]   widx;
  logic                    misalign;
  logic                    bad_load_f3;
  logic                    bad_store_f3;
  logic                    fault_raw;
  logic                    load_go;
  logic                    store_go;
  logic [3:0]              be;
  logic [31:0]             wlane;
  logic                    unused_addr_bits;

  // Upper address bits are deliberately ignored so the address space wraps.
  assign widx             = addr[ADDR_WIDTH+1:2];
  assign unused_addr_bits = ^addr[31:ADDR_WIDTH+2];

  // Select the addressed byte or half from the read word and extend it.
  function automatic logic [31:0] fmt_load(input logic [31:0] word,
                                           input logic [1:0]  off,
                                           input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'd0:    fmt_load = {{24{b[7]}}, b};
      3'd4:    fmt_load = {24'd0, b};
      3'd1:    fmt_load = {{16{h[15]}}, h};
      3'd5:    fmt_load = {16'd0, h};
      default: fmt_load = word;
    endcase
  endfunction

  // Classify the presented request: alignment and func3 legality.
  always_comb begin
    misalign = 1'b0;
    case (func3)
      3'd1, 3'd5: misalign = addr[0];
      3'd2:       misalign = (addr[1:0] != 2'b00);
      default:    misalign = 1'b0;
    endcase
    bad_load_f3  = (func3 == 3'd3) || (func3 == 3'd6) || (func3 == 3'd7);
    bad_store_f3 = (func3 > 3'd2);
    fault_raw    = (MemRead && MemWrite) || misalign ||
                   (MemRead && bad_load_f3) || (MemWrite && bad_store_f3);
  end

  // Byte enables and lane-replicated store data for SB/SH/SW.
  always_comb begin
    be    = 4'b0000;
    wlane = 32'd0;
    case (func3[1:0])
      2'd0: begin
        be    = 4'b0001 << addr[1:0];
        wlane = {4{wdata[7:0]}};
      end
      2'd1: begin
        be    = addr[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wdata[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wlane = wdata;
      end
    endcase
  end

  // Next-state and outputs; nothing is accepted while reset is asserted.
  always_comb begin
    state_d  = state_q;
    off_d    = off_q;
    f3_d     = f3_q;
    fault    = 1'b0;
    stall    = 1'b0;
    rdata    = 32'd0;
    load_go  = 1'b0;
    store_go = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rst && (MemRead || MemWrite)) begin
          fault = fault_raw;
          if (!fault_raw) begin
            if (MemRead) begin
              load_go = 1'b1;
              stall   = 1'b1;
              off_d   = addr[1:0];
              f3_d    = func3;
              state_d = READ;
            end else begin
              store_go = 1'b1;
            end
          end
        end
      end
      READ: begin
        // Request inputs are still held by the stalled instruction; ignore them.
        rdata   = fmt_load(rword_q, off_q, f3_q);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state; reset cancels any in-flight load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      off_q   <= 2'd0;
      f3_q    <= 3'd0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
    end
  end

  // Storage array: per-byte writes and a registered one-cycle read; never reset.
  always_ff @(posedge clk) begin
    if (store_go) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[widx][8*b +: 8] <= wlane[8*b +: 8];
      end
    end
    if (load_go) rword_q <= mem[widx];
  end

endmodule

// File: doc/data_mem_unit.md
DATA_MEM_UNIT -- requirements
Module: data_mem_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, meaning word-address bits (2^ADDR_WIDTH 32-bit words).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port MemRead  input  1  load request from the control unit.
REQ-005 SHALL have port MemWrite  input  1  store request from the control unit.
REQ-006 SHALL have port func3  input  3  access size/sign: 0 B, 1 H, 2 W, 4 BU, 5 HU.
REQ-007 SHALL have port addr  input  32  byte address (ALU result).
REQ-008 SHALL have port wdata  input  32  store data; lane 0 holds the B/H payload.
REQ-009 SHALL have port rdata  output  32  formatted load result.
REQ-010 SHALL have port stall  output  1  holds the pipeline while a load is pending.
REQ-011 SHALL have port fault  output  1  access rejected (misaligned, illegal func3, or both requests).

Function
REQ-012 SHALL contain a 2^ADDR_WIDTH x 32 array with per-byte write enables and a 1-cycle synchronous read.
REQ-013 SHALL index words with addr[ADDR_WIDTH+1:2]; upper address bits are ignored, so addresses wrap.
REQ-014 SHALL use little-endian byte lanes selected by addr[1:0].
REQ-015 SHALL implement FSM states IDLE and READ; reset state IDLE.
REQ-016 SHALL assert fault combinationally in IDLE for any of these:
- MemRead and MemWrite both high.
- H/HU with addr[0]=1.
- W with addr[1:0]!=0.
- Load func3 of 3, 6 or 7.
- Store func3 above 2.
REQ-017 SHALL hold fault at 0 in READ and when neither request is high.
REQ-018 SHALL perform no memory access, leave stall 0 and stay in IDLE when fault=1.
REQ-019 SHALL handle a valid store in IDLE without stalling, writing at that clock edge:
- SB: one byte, wdata[7:0], lane addr[1:0].
- SH: two bytes, wdata[15:0], lanes addr[1]*2 and +1.
- SW: all four bytes.
REQ-020 SHALL handle a valid load in IDLE as follows:
- Issue an array read.
- Latch addr[1:0] and func3.
- Assert stall=1 combinationally in that cycle.
- Go to READ.
REQ-021 SHALL in READ drive stall=0 and rdata as follows:
- LB/LH: selected byte/half, sign-extended.
- LBU/LHU: zero-extended.
- LW: the whole word.
Then return to IDLE unconditionally.
REQ-022 SHALL ignore MemRead and MemWrite while in READ, because the held instruction still presents them.
REQ-023 SHALL drive rdata to 0 in IDLE.
REQ-024 SHALL give a load a latency of exactly 2 cycles (request cycle plus READ), with stall high for exactly 1 cycle.
REQ-025 SHALL allow back-to-back loads: a new load accepted in the IDLE cycle after READ stalls again for one cycle.
REQ-026 SHALL, on a store immediately followed by a load to the same word, return the newly written data.

Reset
REQ-027 SHALL on rst=1, asynchronously:
- Force the FSM to IDLE.
- Drive stall=0, fault=0 and rdata=0.
- Cancel any in-flight load.
REQ-028 SHALL leave memory contents unchanged by reset; memory contents are undefined at power-up.
REQ-029 SHALL not start any access while rst is high, whatever the request inputs.

Verification
REQ-030 SHALL cover word store/load:
- SW 0xDEADBEEF @0x10, then LW @0x10.
- Required: stall=1 for one cycle, then rdata=0xDEADBEEF.
REQ-031 SHALL cover byte/half sign handling after REQ-030:
- LB @0x13 -> 0xFFFFFFDE.
- LBU @0x13 -> 0x000000DE.
- LH @0x12 -> 0xFFFFDEAD.
- LHU @0x10 -> 0x0000BEEF.
REQ-032 SHALL cover partial store:
- SB wdata=0x00000055 @0x11, then LW @0x10 -> 0xDEAD55EF.
- SH wdata=0x1234 @0x12, then LW @0x10 -> 0x123455EF.
REQ-033 SHALL cover faults:
- LW @0x12, SH @0x01, load func3=3, or MemRead=MemWrite=1 each give fault=1 and stall=0.
- A following LW @0x10 is unchanged.
REQ-034 SHALL cover reset mid-load:
- Assert rst in the READ cycle of LW @0x10.
- Required: stall=0 and rdata=0 immediately, FSM in IDLE.
- After release, LW @0x10 still returns the stored value.
REQ-035 SHALL cover address wrap:
- With ADDR_WIDTH=10, SW 0xA5A5A5A5 @0x1010, then LW @0x10 -> 0xA5A5A5A5.
